// File: rtl/cke_sched_pkg.sv
// Shared types and helpers for the clock-enable scheduler: FSM state encoding
// and the phase clamp used whenever a channel counter is (re)loaded.
package cke_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_READY  = 2'd2,
    ST_RUN    = 2'd3
  } state_e;

  // Widest period/phase field the clamp helper handles.
  localparam int unsigned CLAMP_W = 32;

  // Initial count for a channel: min(phase, period-1), or 0 when the channel
  // is disabled (period 0), so the first fire never lands beyond one period.
  function automatic logic [CLAMP_W-1:0] clamp_phase(
    input logic [CLAMP_W-1:0] phase_v,
    input logic [CLAMP_W-1:0] period_v
  );
    logic [CLAMP_W-1:0] last_v;
    if (period_v == '0) begin
      return '0;
    end
    last_v = period_v - CLAMP_W'(1);
    return (phase_v > last_v) ? last_v : phase_v;
  endfunction

endpackage : cke_sched_pkg

// File: rtl/cke_sched_chan.sv
// One enable channel: a down-counter that fires when it is advanced at zero,
// reloading to period-1, with a registered (latency-1) enable output.
module cke_chan
  import cke_sched_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             adv,
  input  logic             load,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] phase,
  output logic             cke
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cke_q, cke_d;

  // NOTE: every variable is given a default before any branch so the block
  // stays purely combinational; a missing default would infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    cke_d = 1'b0;
    if (load) begin
      cnt_d = CNT_W'(clamp_phase(CLAMP_W'(phase), CLAMP_W'(period)));
    end else if (adv && (period != '0)) begin
      if (cnt_q == '0) begin
        cke_d = 1'b1;
        cnt_d = period - CNT_W'(1);
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_q <= '0;
      cke_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      cke_q <= cke_d;
    end
  end

  assign cke = cke_q;

endmodule : cke_chan

// File: rtl/cke_sched.sv
// N-channel clock-enable scheduler: lock synchroniser and settle gate, run /
// pause / single-step FSM, shadow period/phase registers and the tick count.
module cke_sched
  import cke_sched_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned LOCK_WAIT = 1024,
  parameter int unsigned TICK_W    = 32
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  locked,
  input  logic                  run,
  input  logic                  step,
  input  logic                  cfg_load,
  input  logic [N_CH*CNT_W-1:0] period,
  input  logic [N_CH*CNT_W-1:0] phase,
  output logic [N_CH-1:0]       cke,
  output logic                  active,
  output logic                  ready,
  output logic                  cfg_err,
  output logic [TICK_W-1:0]     tick
);

  localparam int unsigned SET_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(LOCK_WAIT - 1);

  logic [1:0]            sync_q;
  logic                  locked_s;
  state_e                state_q, state_d;
  logic [SET_W-1:0]      settle_q, settle_d;
  logic [N_CH*CNT_W-1:0] per_q, per_d, ph_q, ph_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic                  active_q, ready_q, cfg_err_q;
  logic                  cfg_accept, lock_lost, load, adv;

  assign locked_s = sync_q[1];

  // Any counter reload (accepted config or lock loss) takes priority over an
  // advance, so a load never coincides with a fire and tick restarts at 0.
  always_comb begin
    cfg_accept = cfg_load && (state_q != ST_RUN);
    lock_lost  = !locked_s && (state_q != ST_IDLE);
    load       = cfg_accept || lock_lost;
    adv        = !load && ((state_q == ST_RUN) || ((state_q == ST_READY) && step));
    per_d      = cfg_accept ? period : per_q;
    ph_d       = cfg_accept ? phase  : ph_q;
    if (load) begin
      tick_d = '0;
    end else if (adv) begin
      tick_d = tick_q + TICK_W'(1);
    end else begin
      tick_d = tick_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      ST_IDLE: begin
        if (locked_s) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = ST_READY;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      ST_READY: if (run)  state_d = ST_RUN;
      ST_RUN:   if (!run) state_d = ST_READY;
      default:  state_d = ST_IDLE;
    endcase
    if (!locked_s) begin
      state_d = ST_IDLE;
    end
  end

  // Shadow registers reset to 0 so every channel starts disabled.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync_q    <= 2'b00;
      state_q   <= ST_IDLE;
      settle_q  <= '0;
      per_q     <= '0;
      ph_q      <= '0;
      tick_q    <= '0;
      active_q  <= 1'b0;
      ready_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], locked};
      state_q   <= state_d;
      settle_q  <= settle_d;
      per_q     <= per_d;
      ph_q      <= ph_d;
      tick_q    <= tick_d;
      active_q  <= (state_d == ST_RUN);
      ready_q   <= (state_d == ST_READY) || (state_d == ST_RUN);
      cfg_err_q <= cfg_load && (state_q == ST_RUN);
    end
  end

  // Channels see the next-state shadow so an accepted load applies the new
  // period and phase on the same edge that captures them.
  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    cke_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk_sys (clk_sys),
      .reset   (reset),
      .adv     (adv),
      .load    (load),
      .period  (per_d[g*CNT_W +: CNT_W]),
      .phase   (ph_d[g*CNT_W +: CNT_W]),
      .cke     (cke[g])
    );
  end

  assign active  = active_q;
  assign ready   = ready_q;
  assign cfg_err = cfg_err_q;
  assign tick    = tick_q;

endmodule : cke_sched

// File: tb/tb_cke_sched.sv
// Directed bench for cke_sched: settle timing, enable patterns, pause/resume,
// single step, config rejection and lock loss / reset recovery.
module tb_cke_sched;

  localparam int N_CH   = 4;
  localparam int CNT_W  = 16;
  localparam int TICK_W = 32;

  logic                  clk_sys = 1'b0;
  logic                  reset;
  logic                  locked;
  logic                  run;
  logic                  step;
  logic                  cfg_load;
  logic [N_CH*CNT_W-1:0] period;
  logic [N_CH*CNT_W-1:0] phase;
  logic [N_CH-1:0]       cke;
  logic                  active;
  logic                  ready;
  logic                  cfg_err;
  logic [TICK_W-1:0]     tick;

  int checks   = 0;
  int failures = 0;
  int ch2_hits;

  cke_sched #(
    .N_CH      (N_CH),
    .CNT_W     (CNT_W),
    .LOCK_WAIT (8),
    .TICK_W    (TICK_W)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .locked   (locked),
    .run      (run),
    .step     (step),
    .cfg_load (cfg_load),
    .period   (period),
    .phase    (phase),
    .cke      (cke),
    .active   (active),
    .ready    (ready),
    .cfg_err  (cfg_err),
    .tick     (tick)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges and settle 1 time unit past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // Expected enables for periods {1,2,3,0}, phases {0,1,0,5}, advance c (from 1):
  // ch0 every advance, ch1 on even advances, ch2 on advances 1,4,7,...
  function automatic logic [3:0] exp_cke(input int c);
    return {1'b0, (c % 3) == 1, (c % 2) == 0, 1'b1};
  endfunction

  task automatic set_cfg(input logic [15:0] p3, p2, p1, p0,
                         input logic [15:0] h3, h2, h1, h0);
    period = {p3, p2, p1, p0};
    phase  = {h3, h2, h1, h0};
  endtask

  initial begin
    reset = 1'b1; locked = 1'b0; run = 1'b1; step = 1'b0; cfg_load = 1'b0;
    set_cfg(16'd0, 16'd3, 16'd2, 16'd1, 16'd5, 16'd0, 16'd1, 16'd0);
    cyc(3);
    check("rst_cke", 64'(cke), 64'h0);
    check("rst_active", 64'(active), 64'h0);
    check("rst_ready", 64'(ready), 64'h0);
    check("rst_cfg_err", 64'(cfg_err), 64'h0);
    check("rst_tick", 64'(tick), 64'h0);
    reset = 1'b0;

    // Load in IDLE, then lock: READY 11 edges later, RUN 12 edges later.
    cfg_load = 1'b1;
    cyc(1);
    cfg_load = 1'b0;
    check("idle_cfg_err", 64'(cfg_err), 64'h0);
    locked = 1'b1;
    cyc(10);
    check("settle_ready", 64'(ready), 64'h0);
    check("settle_cke", 64'(cke), 64'h0);
    cyc(1);
    check("ready_rise", 64'(ready), 64'h1);
    check("ready_active", 64'(active), 64'h0);
    cyc(1);
    check("run_active", 64'(active), 64'h1);
    check("run_first_cke", 64'(cke), 64'h0);

    for (int c = 1; c <= 6; c++) begin
      cyc(1);
      check($sformatf("pat_c%0d", c), 64'(cke), 64'(exp_cke(c)));
    end
    check("pat_tick", 64'(tick), 64'd6);

    // Pause: the edge that sees run=0 is still a RUN (advance) edge.
    run = 1'b0;
    cyc(1);
    check("pause_c7", 64'(cke), 64'(exp_cke(7)));
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check($sformatf("pause_cke%0d", i), 64'(cke), 64'h0);
      check($sformatf("pause_tick%0d", i), 64'(tick), 64'd7);
    end
    check("pause_ready", 64'(ready), 64'h1);
    check("pause_active", 64'(active), 64'h0);
    run = 1'b1;
    cyc(1);
    check("resume_cke0", 64'(cke), 64'h0);
    for (int c = 8; c <= 10; c++) begin
      cyc(1);
      check($sformatf("resume_c%0d", c), 64'(cke), 64'(exp_cke(c)));
    end
    check("resume_tick", 64'(tick), 64'd10);

    // cfg_load in RUN is rejected; pattern continues with the old periods.
    set_cfg(16'd5, 16'd5, 16'd5, 16'd5, 16'd0, 16'd0, 16'd0, 16'd0);
    cfg_load = 1'b1;
    cyc(1);
    cfg_load = 1'b0;
    check("rej_cfg_err", 64'(cfg_err), 64'h1);
    check("rej_c11", 64'(cke), 64'(exp_cke(11)));
    cyc(1);
    check("rej_cfg_err_pulse", 64'(cfg_err), 64'h0);
    check("rej_c12", 64'(cke), 64'(exp_cke(12)));
    run = 1'b0;
    cyc(1);
    check("rej_c13", 64'(cke), 64'(exp_cke(13)));
    check("to_ready", 64'(ready), 64'h1);

    // Load + step in READY: load wins, no advance, tick cleared; ch2 phase 1.
    set_cfg(16'd0, 16'd3, 16'd2, 16'd1, 16'd0, 16'd1, 16'd0, 16'd0);
    cfg_load = 1'b1; step = 1'b1;
    cyc(1);
    cfg_load = 1'b0; step = 1'b0;
    check("ldstep_cke", 64'(cke), 64'h0);
    check("ldstep_tick", 64'(tick), 64'd0);
    check("ldstep_cfg_err", 64'(cfg_err), 64'h0);

    ch2_hits = 0;
    for (int s = 1; s <= 3; s++) begin
      step = 1'b1;
      cyc(1);
      step = 1'b0;
      ch2_hits += int'(cke[2]);
      check($sformatf("step%0d_cke", s), 64'(cke), (s == 2) ? 64'h5 : 64'h3);
      cyc(1);
      check($sformatf("step%0d_idle", s), 64'(cke), 64'h0);
    end
    check("step_ch2_pulses", 64'(ch2_hits), 64'd1);
    check("step_tick", 64'(tick), 64'd3);

    // Back to RUN, then drop lock: enables gone within 3 edges.
    run = 1'b1;
    cyc(1);
    check("rerun_active", 64'(active), 64'h1);
    cyc(1);
    check("rerun_cke", 64'(cke), 64'h1);
    locked = 1'b0;
    cyc(3);
    check("loss_cke", 64'(cke), 64'h0);
    check("loss_ready", 64'(ready), 64'h0);
    check("loss_active", 64'(active), 64'h0);

    // Lock returns: counters restart from phase {0,1,0,0}.
    locked = 1'b1;
    cyc(12);
    check("relock_active", 64'(active), 64'h1);
    check("relock_cke0", 64'(cke), 64'h0);
    cyc(1);
    check("relock_c1", 64'(cke), 64'h3);
    cyc(1);
    check("relock_c2", 64'(cke), 64'h5);

    // Synchronous reset mid-RUN clears everything, shadow included.
    reset = 1'b1;
    cyc(1);
    check("mrst_cke", 64'(cke), 64'h0);
    check("mrst_active", 64'(active), 64'h0);
    check("mrst_ready", 64'(ready), 64'h0);
    check("mrst_tick", 64'(tick), 64'h0);
    reset = 1'b0;
    cyc(12);
    check("mrst_run", 64'(active), 64'h1);
    cyc(1);
    check("mrst_disabled_cke", 64'(cke), 64'h0);
    check("mrst_tick_adv", 64'(tick), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_cke_sched
